// File: rtl/spi_cfg_sequencer.sv
// Streams a table of 24-bit {reg_addr, reg_data} entries into a byte-wide SPI transmitter, one 3-byte frame per entry.
// Optional per-frame watchdog: define SPI_SEQ_TIMEOUT_EN.

module spi_cfg_sequencer #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_waddr,
  input  logic [23:0]       cfg_wdata,
  input  logic [ADDR_W:0]   num_entries,
  input  logic              start,
  output logic              busy,
  output logic              seq_done,
  output logic [ADDR_W-1:0] cur_index,
  output logic              error,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic              tx_data_ready,
  input  logic              tx_data_req,
  input  logic              tx_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W:0]  DEPTH_N  = (ADDR_W + 1)'(DEPTH);

  logic [23:0]       mem [DEPTH];
  logic [23:0]       rdata_q;
  logic              mem_we;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   n_start;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic              ready_q, ready_d;
  logic              seq_done_q, seq_done_d;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              error_q, error_d;
`endif

  assign mem_we  = cfg_we && (state_q == S_IDLE);
  assign n_start = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;

  // Registered table read addressed by next index, so the entry is ready when LOAD runs.
  // A write landing on that address in the same cycle is forwarded (start and write together).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cfg_waddr] <= cfg_wdata;
    end
    if (mem_we && (cfg_waddr == idx_d)) begin
      rdata_q <= cfg_wdata;
    end else begin
      rdata_q <= mem[idx_d];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    shift_d    = shift_q;
    ready_d    = ready_q;
    seq_done_d = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
    wd_d       = wd_q;
    error_d    = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d = '0;
          n_d   = n_start;
`ifdef SPI_SEQ_TIMEOUT_EN
          error_d = 1'b0;
`endif
          if (n_start == '0) begin
            seq_done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        shift_d    = rdata_q;
        byte_cnt_d = 2'd0;
        ready_d    = 1'b1;
        state_d    = S_SEND;
`ifdef SPI_SEQ_TIMEOUT_EN
        wd_d       = '0;
`endif
      end
      S_SEND: begin
        // The transmitter latches the current byte on this edge; present the next one.
        if (tx_data_req) begin
          case (byte_cnt_q)
            2'd0, 2'd1: begin
              shift_d    = {shift_q[15:0], 8'h00};
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
            default: begin
              ready_d = 1'b0;
              state_d = S_WAIT;
            end
          endcase
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          if ({1'b0, idx_q} == (n_q - (ADDR_W + 1)'(1))) begin
            seq_done_d = 1'b1;
            idx_d      = '0;
            state_d    = S_IDLE;
          end else begin
            gap_cnt_d = GAP_INIT;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SPI_SEQ_TIMEOUT_EN
    // A done pulse on the same edge as expiry still completes the frame normally.
    if ((state_q == S_SEND) || ((state_q == S_WAIT) && !tx_done)) begin
      if (wd_q == WD_LAST) begin
        error_d    = 1'b1;
        ready_d    = 1'b0;
        seq_done_d = 1'b1;
        idx_d      = '0;
        state_d    = S_IDLE;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      byte_cnt_q <= 2'd0;
      gap_cnt_q  <= '0;
      shift_q    <= 24'h0;
      ready_q    <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      shift_q    <= shift_d;
      ready_q    <= ready_d;
      seq_done_q <= seq_done_d;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign error = 1'b0;
`endif

  assign busy      = (state_q != S_IDLE);
  assign tx_en     = (state_q != S_IDLE);
  assign seq_done  = seq_done_q;
  assign cur_index = idx_q;
  assign tx_data   = shift_q[23:16];
  // Drop valid as soon as reset is seen so the transmitter cannot start another byte.
  assign tx_data_ready = ready_q & ~rst;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer with a simple byte-wide SPI transmitter model.
// The timeout scenario is compiled only when SPI_SEQ_TIMEOUT_EN is defined.

module tb_spi_cfg_sequencer;

  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int GAP_CYCLES = 8;
  localparam int TIMEOUT_CYCLES = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [ADDR_W-1:0] cfg_waddr = '0;
  logic [23:0]       cfg_wdata = '0;
  logic [ADDR_W:0]   num_entries = '0;
  logic              start = 1'b0;
  logic              busy, seq_done, error, tx_en, tx_data_ready;
  logic [ADDR_W-1:0] cur_index;
  logic [7:0]        tx_data;
  logic              tx_data_req = 1'b0;
  logic              tx_done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_cfg_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
    .num_entries(num_entries), .start(start), .busy(busy), .seq_done(seq_done),
    .cur_index(cur_index), .error(error), .tx_en(tx_en), .tx_data(tx_data),
    .tx_data_ready(tx_data_ready), .tx_data_req(tx_data_req), .tx_done(tx_done)
  );

  // Cycle counter and tx_done bookkeeping, both sampled on the active edge.
  int cyc = 0;
  int done_cnt = 0;
  int done_at = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) begin
      done_cnt <= done_cnt + 1;
      done_at  <= cyc;
    end
  end

  // Transmitter model: requests a byte, shifts for 4 clocks, chains while ready stays high.
  bit         model_en = 1'b1;
  bit         m_cs = 1'b1;
  int         m_cnt = 0;
  int         frame_cnt = 0;
  logic [7:0] cap_b[$];
  int         cap_f[$];
  always @(negedge clk) begin
    tx_data_req = 1'b0;
    tx_done     = 1'b0;
    if (!model_en) begin
      m_cs  = 1'b1;
      m_cnt = 0;
    end else if (m_cs) begin
      if (tx_en && tx_data_ready) begin
        m_cs = 1'b0;
        frame_cnt++;
        tx_data_req = 1'b1;
        cap_b.push_back(tx_data);
        cap_f.push_back(frame_cnt);
        m_cnt = 3;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
    end else if (tx_data_ready) begin
      tx_data_req = 1'b1;
      cap_b.push_back(tx_data);
      cap_f.push_back(frame_cnt);
      m_cnt = 3;
    end else begin
      tx_done = 1'b1;
      m_cs    = 1'b1;
    end
  end

  // Results of the most recent run_seq
  int sd_cnt, sd_t, sd_dcnt, busy_low, ready_t;
  int rise_cyc[$];
  int rise_idx[$];
  int rise_dat[$];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [ADDR_W-1:0] a, input logic [23:0] d);
    cfg_we = 1'b1; cfg_waddr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  // Pulses start and records what happens over ncyc cycles; poke re-pulses start and writes entry 1.
  task automatic run_seq(input logic [ADDR_W:0] n, input bit poke, input int ncyc);
    int  done_base;
    bit  prev_ready;
    cap_b.delete(); cap_f.delete();
    rise_cyc.delete(); rise_idx.delete(); rise_dat.delete();
    sd_cnt = 0; sd_t = -1; sd_dcnt = -1; busy_low = 0; ready_t = -1;
    prev_ready = 1'b0;
    done_base = done_cnt;
    num_entries = n;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= ncyc; t++) begin
      if (seq_done) begin
        sd_cnt++;
        if (sd_t < 0) begin
          sd_t = t;
          sd_dcnt = done_cnt - done_base;
        end
      end
      if (sd_t < 0 && !busy && n != 0) busy_low++;
      if (tx_data_ready && !prev_ready) begin
        if (ready_t < 0) ready_t = t;
        rise_cyc.push_back(cyc);
        rise_idx.push_back(int'(cur_index));
        rise_dat.push_back(done_at);
      end
      prev_ready = tx_data_ready;
      start = 1'b0; cfg_we = 1'b0;
      if (poke && (t == 5 || t == 25)) begin
        start = 1'b1; cfg_we = 1'b1; cfg_waddr = 4'd1; cfg_wdata = 24'hFFFFFF;
      end
      step();
    end
    start = 1'b0; cfg_we = 1'b0;
    $display("run_seq n=%0d: %0d bytes, %0d seq_done, first seq_done at t=%0d", n, cap_b.size(), sd_cnt, sd_t);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_seq_done: got %b want 0", seq_done); end
    checks++; if (cur_index !== 4'd0) begin errors++; $display("FAIL reset_cur_index: got %0d want 0", cur_index); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (tx_data_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_data_ready: got %b want 0", tx_data_ready); end
    rst = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h31; exp_b[1] = 8'h0A; exp_b[2] = 8'h55;
    write_entry(4'd0, 24'h310A55);
    run_seq(5'd1, 1'b0, 60);
    checks++; if (cap_b.size() != 3) begin errors++; $display("FAIL single_nbytes: got %0d want 3", cap_b.size()); end
    for (int i = 0; i < 3 && i < cap_b.size(); i++) begin
      checks++; if (cap_b[i] !== exp_b[i]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, cap_b[i], exp_b[i]); end
      checks++; if (cap_f[i] != cap_f[0]) begin errors++; $display("FAIL single_frame%0d: got frame %0d want %0d", i, cap_f[i], cap_f[0]); end
    end
    checks++; if (sd_cnt != 1) begin errors++; $display("FAIL single_seq_done_count: got %0d want 1", sd_cnt); end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL single_busy: low for %0d cycles before seq_done, want 0", busy_low); end
    checks++; if (ready_t != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", ready_t); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_multi();
    logic [7:0] exp_b[9];
    exp_b = '{8'h12, 8'h34, 8'h56, 8'hA5, 8'h00, 8'hFF, 8'h7E, 8'hC3, 8'h81};
    write_entry(4'd0, 24'h123456);
    write_entry(4'd1, 24'hA500FF);
    write_entry(4'd2, 24'h7EC381);
    run_seq(5'd3, 1'b0, 120);
    checks++; if (cap_b.size() != 9) begin errors++; $display("FAIL multi_nbytes: got %0d want 9", cap_b.size()); end
    for (int i = 0; i < 9 && i < cap_b.size(); i++) begin
      checks++; if (cap_b[i] !== exp_b[i]) begin errors++; $display("FAIL multi_byte%0d: got %h want %h", i, cap_b[i], exp_b[i]); end
      checks++; if (cap_f[i] != cap_f[0] + i / 3) begin errors++; $display("FAIL multi_frame%0d: got %0d want %0d", i, cap_f[i], cap_f[0] + i / 3); end
    end
    checks++; if (rise_idx.size() != 3) begin errors++; $display("FAIL multi_nframes: got %0d want 3", rise_idx.size()); end
    for (int k = 0; k < 3 && k < rise_idx.size(); k++) begin
      checks++; if (rise_idx[k] != k) begin errors++; $display("FAIL multi_cur_index%0d: got %0d want %0d", k, rise_idx[k], k); end
      if (k > 0) begin
        // tx_done cycle, 8 gap cycles, LOAD, then ready: 10 cycles
        checks++; if (rise_cyc[k] - rise_dat[k] != 10) begin errors++; $display("FAIL multi_gap%0d: got %0d want 10", k, rise_cyc[k] - rise_dat[k]); end
      end
    end
    checks++; if (sd_cnt != 1) begin errors++; $display("FAIL multi_seq_done_count: got %0d want 1", sd_cnt); end
    checks++; if (sd_dcnt != 3) begin errors++; $display("FAIL multi_seq_done_after: tx_done count %0d want 3", sd_dcnt); end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL multi_busy: low for %0d cycles, want 0", busy_low); end
  endtask

  task automatic test_zero();
    run_seq(5'd0, 1'b0, 15);
    checks++; if (sd_t != 1) begin errors++; $display("FAIL zero_seq_done_time: got %0d want 1", sd_t); end
    checks++; if (sd_cnt != 1) begin errors++; $display("FAIL zero_seq_done_count: got %0d want 1", sd_cnt); end
    checks++; if (ready_t != -1) begin errors++; $display("FAIL zero_ready: asserted at t=%0d want never", ready_t); end
    checks++; if (cap_b.size() != 0) begin errors++; $display("FAIL zero_bytes: got %0d want 0", cap_b.size()); end
  endtask

  task automatic test_ignore();
    logic [7:0] exp_b[6];
    exp_b = '{8'h20, 8'h11, 8'h11, 8'h21, 8'h22, 8'h22};
    write_entry(4'd0, 24'h201111);
    write_entry(4'd1, 24'h212222);
    run_seq(5'd2, 1'b1, 120);
    checks++; if (cap_b.size() != 6) begin errors++; $display("FAIL ignore_nbytes: got %0d want 6", cap_b.size()); end
    for (int i = 0; i < 6 && i < cap_b.size(); i++) begin
      checks++; if (cap_b[i] !== exp_b[i]) begin errors++; $display("FAIL ignore_byte%0d: got %h want %h", i, cap_b[i], exp_b[i]); end
    end
    checks++; if (sd_cnt != 1) begin errors++; $display("FAIL ignore_seq_done_count: got %0d want 1", sd_cnt); end
    // Rerun to confirm the busy-time write to entry 1 never landed.
    run_seq(5'd2, 1'b0, 120);
    for (int i = 3; i < 6 && i < cap_b.size(); i++) begin
      checks++; if (cap_b[i] !== exp_b[i]) begin errors++; $display("FAIL ignore_table_byte%0d: got %h want %h", i, cap_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int bound;
    int sd_seen = 0;
    int busy_seen = 0;
    write_entry(4'd0, 24'h5AC3E7);
    cap_b.delete(); cap_f.delete();
    num_entries = 5'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    bound = 0;
    while (cap_b.size() < 2 && bound < 40) begin
      step();
      bound++;
    end
    checks++; if (cap_b.size() < 2) begin errors++; $display("FAIL rstmid_reach_byte2: got %0d bytes want 2", cap_b.size()); end
    rst = 1'b1;
    #1;
    checks++; if (tx_data_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_immediate: got %b want 0", tx_data_ready); end
    step();
    checks++; if (tx_data_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", tx_data_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (cur_index !== 4'd0) begin errors++; $display("FAIL rstmid_cur_index: got %0d want 0", cur_index); end
    rst = 1'b0;
    for (int t = 0; t < 30; t++) begin
      step();
      if (seq_done) sd_seen++;
      if (busy || tx_data_ready) busy_seen++;
    end
    checks++; if (sd_seen != 0) begin errors++; $display("FAIL rstmid_stray_done: seq_done %0d times want 0", sd_seen); end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL rstmid_stray_busy: active %0d cycles want 0", busy_seen); end
    run_seq(5'd1, 1'b0, 60);
    checks++; if (cap_b.size() != 3) begin errors++; $display("FAIL rstmid_nbytes: got %0d want 3", cap_b.size()); end
    if (cap_b.size() == 3) begin
      checks++; if (cap_b[0] !== 8'h5A) begin errors++; $display("FAIL rstmid_byte0: got %h want 5a", cap_b[0]); end
      checks++; if (cap_b[1] !== 8'hC3) begin errors++; $display("FAIL rstmid_byte1: got %h want c3", cap_b[1]); end
      checks++; if (cap_b[2] !== 8'hE7) begin errors++; $display("FAIL rstmid_byte2: got %h want e7", cap_b[2]); end
    end
    checks++; if (sd_cnt != 1) begin errors++; $display("FAIL rstmid_seq_done_count: got %0d want 1", sd_cnt); end
  endtask

`ifdef SPI_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    model_en = 1'b0;
    step();
    write_entry(4'd0, 24'h010203);
    run_seq(5'd1, 1'b0, 300);
    checks++; if (sd_t != 258) begin errors++; $display("FAIL timeout_time: got %0d want 258", sd_t); end
    checks++; if (sd_cnt != 1) begin errors++; $display("FAIL timeout_seq_done_count: got %0d want 1", sd_cnt); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", error); end
    checks++; if (busy !== 1'b0 || tx_data_ready !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy %b ready %b want 0 0", busy, tx_data_ready); end
    model_en = 1'b1;
    num_entries = 5'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", error); end
    repeat (60) step();
    checks++; if (error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_recover: error %b busy %b want 0 0", error, busy); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_ignore();
    test_reset_mid();
`ifdef SPI_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cfg_sequencer.md
Name: spi_cfg_sequencer

Overview:
- Sequences a table of 24-bit SPI register writes, e.g. ADC or PGA configuration, into the byte-wide SPI transmitter.
- Each table entry is sent as one 3-byte frame with chip select held low across the frame. Frames are separated by a programmable idle gap.
- Sits between the host/config register block and the SPI transmitter. It owns the transmitter's data/data_ready/en inputs.

Parameters:
- DEPTH, 16, number of table entries (power of two).
- ADDR_W, 4, log2(DEPTH).
- GAP_CYCLES, 8, idle clocks between the transmitter's done pulse and the next frame (minimum 1).
- TIMEOUT_CYCLES, 256, watchdog limit per frame (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_waddr  in  ADDR_W  table write address.
- cfg_wdata  in  24  entry {reg_addr[7:0], reg_data[15:0]}.
- num_entries  in  ADDR_W+1  entries to send, from index 0; sampled on start.
- start  in  1  single-cycle start request.
- busy  out  1  high from the accepted start until seq_done.
- seq_done  out  1  one-cycle pulse at the end of a sequence.
- cur_index  out  ADDR_W  index of the entry currently being sent.
- error  out  1  sticky; timeout flag (optional feature), cleared by start.
- tx_en  out  1  transmitter enable.
- tx_data  out  8  byte presented to the transmitter.
- tx_data_ready  out  1  tx_data is valid.
- tx_data_req  in  1  transmitter pulse: tx_data is consumed at this edge.
- tx_done  in  1  transmitter pulse: frame ended, CS released.

Behaviour:
- Reset values: busy=0, seq_done=0, cur_index=0, error=0, tx_en=0, tx_data=0, tx_data_ready=0. Internal state is IDLE; the table contents are not cleared.
- Table: synchronous write when cfg_we=1 and state is IDLE. Writes in any other state are dropped.
- Start: accepted only in IDLE. A start received in any other state is ignored.
  - On accept: latch n = min(num_entries, DEPTH); clear error; busy=1.
  - If n=0, pulse seq_done on the next cycle, return to IDLE, and generate no tx traffic.
- States: IDLE, LOAD, SEND, WAIT_DONE, GAP.
- IDLE -> LOAD on an accepted start with n>0.
- LOAD (1 cycle):
  - Read entry[cur_index] into a 24-bit shift register.
  - tx_data <= reg_addr; byte_cnt <= 0; tx_data_ready <= 1.
  - Go to SEND.
- SEND: tx_data_ready stays high. On each edge with tx_data_req=1:
  - byte_cnt 0 -> 1: tx_data <= reg_data[15:8].
  - byte_cnt 1 -> 2: tx_data <= reg_data[7:0].
  - byte_cnt 2: tx_data_ready <= 0, go to WAIT_DONE.
  - Byte order is MSB first: addr, data high, data low.
  - tx_data changes only on the edge where tx_data_req=1. The transmitter latches the old value on that same edge.
  - Because tx_data_ready is kept high between bytes, the transmitter chains back-to-back and CS stays low for all 3 bytes.
- WAIT_DONE: wait for tx_done=1.
  - If cur_index = n-1: pulse seq_done, busy <= 0, cur_index <= 0, tx_en <= 0, go to IDLE.
  - Otherwise: load gap_cnt = GAP_CYCLES-1, go to GAP.
- GAP: decrement gap_cnt. At 0: cur_index <= cur_index+1, go to LOAD.
- tx_en is high in every state except IDLE.
- A tx_done or tx_data_req seen in IDLE, LOAD or GAP is ignored.
- Reset mid-frame: all outputs return to reset values on the next edge, and tx_data_ready drops immediately. Any done pulse the transmitter later emits from its unfinished frame is ignored. No partial frame is re-sent.
- Latency: from start to the first tx_data_ready is 2 cycles.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter is cleared in LOAD and increments in SEND and WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES before tx_done, then: error <= 1, tx_data_ready <= 0, seq_done is pulsed, busy <= 0, and the state returns to IDLE. The remaining entries are skipped.
- Without the macro: no counter is built, error is tied 0, and the sequencer waits on tx_done indefinitely.

Test Plan:
- Write entry0=0x31_0A55, num_entries=1, start, with the transmitter model attached -> sdo bytes 0x31, 0x0A, 0x55 in one CS-low frame; exactly one seq_done pulse; busy high throughout.
- Write 3 entries, num_entries=3, GAP_CYCLES=8 -> 3 separate CS frames; exactly 8 idle clocks from each tx_done to the next LOAD; cur_index reads 0, 1, 2; seq_done only after the third tx_done.
- num_entries=0, start -> seq_done pulses 1 cycle after start; tx_data_ready never asserts.
- start re-pulsed mid-sequence, plus cfg_we to index 1 while busy -> neither the sequence nor the table changes; transmitted bytes match the original entries.
- rst asserted during byte 2 of a frame -> tx_data_ready=0, busy=0, cur_index=0 on the next edge; the stray tx_done is ignored; a new start sends entry 0 correctly.
- SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=256, tx_done held low -> error=1 and seq_done pulse at 256 cycles after LOAD; the next start clears error.
